// File: rtl/lt_cmp.sv
// lt_cmp: registered magnitude comparator, z = (a < b) one cycle after sampling.
// Operands are compared as 8-bit slices combined MSB-first; the top slice
// holds the remainder bits when WIDTH is not a multiple of 8.
// Compile-time option: define LT_SIGNED_EN for two's-complement operands;
// leave it undefined for unsigned operands.
module lt_cmp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             z
);

  localparam int unsigned NSL = (WIDTH + 7) / 8;
  localparam int unsigned PW  = NSL * 8;

  // Comparison keys fed to the unsigned slice network.
  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;

`ifdef LT_SIGNED_EN
  // Inverting both sign bits maps two's-complement order onto unsigned order:
  // differing MSBs resolve to z = a[MSB], equal MSBs fall through to the
  // unsigned compare of the remaining bits.
  assign a_key = {~a[WIDTH-1], a[WIDTH-2:0]};
  assign b_key = {~b[WIDTH-1], b[WIDTH-2:0]};
`else
  assign a_key = a;
  assign b_key = b;
`endif

  logic [PW-1:0] a_pad;
  logic [PW-1:0] b_pad;

  // Zero-pad both keys to a whole number of slices; identical padding on
  // both sides leaves the top-slice comparison unaffected.
  always_comb begin
    a_pad            = '0;
    b_pad            = '0;
    a_pad[WIDTH-1:0] = a_key;
    b_pad[WIDTH-1:0] = b_key;
  end

  logic [NSL-1:0] slice_lt;
  logic [NSL-1:0] slice_eq;

  for (genvar g = 0; g < NSL; g++) begin : g_slice
    assign slice_lt[g] = a_pad[g*8 +: 8] <  b_pad[g*8 +: 8];
    assign slice_eq[g] = a_pad[g*8 +: 8] == b_pad[g*8 +: 8];
  end

  logic lt_next;

  // Fold slices upward: each higher slice decides unless equal, in which case
  // the verdict of the slices below it passes through.
  always_comb begin
    lt_next = 1'b0;
    for (int unsigned i = 0; i < NSL; i++) begin
      lt_next = slice_lt[i] | (slice_eq[i] & lt_next);
    end
  end

  // Output register; reset wins over the sampled comparison.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z <= 1'b0;
    end else begin
      z <= lt_next;
    end
  end

endmodule

// File: tb/tb_lt_cmp.sv
// Testbench for lt_cmp: directed vectors on a 32-bit instance plus random
// sweeps on 32-bit and 12-bit instances. Honours LT_SIGNED_EN.
module tb_lt_cmp;

  logic        clk;
  logic        rst_n;
  logic [31:0] a32;
  logic [31:0] b32;
  logic [11:0] a12;
  logic [11:0] b12;
  logic        z32;
  logic        z12;

  int checks;
  int errors;

  lt_cmp #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a32),
    .b     (b32),
    .z     (z32)
  );

  lt_cmp #(.WIDTH(12)) dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a12),
    .b     (b12),
    .z     (z12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref32(input logic [31:0] x, input logic [31:0] y);
`ifdef LT_SIGNED_EN
    return $signed(x) < $signed(y);
`else
    return x < y;
`endif
  endfunction

  function automatic logic ref12(input logic [11:0] x, input logic [11:0] y);
`ifdef LT_SIGNED_EN
    return $signed(x) < $signed(y);
`else
    return x < y;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a32 = 32'd0;
    b32 = 32'd1;
    a12 = 12'd0;
    b12 = 12'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (z32 !== 1'b0) begin
        errors++;
        $display("FAIL reset32 cycle %0d: z=%b expected 0", i, z32);
      end
      checks++;
      if (z12 !== 1'b0) begin
        errors++;
        $display("FAIL reset12 cycle %0d: z=%b expected 0", i, z12);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (z32 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release32: z=%b expected 1", z32);
    end
    checks++;
    if (z12 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release12: z=%b expected 1", z12);
    end
  endtask

  task automatic test_ordering();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        ve [3];
    va[0] = 32'd5; vb[0] = 32'd5; ve[0] = 1'b0;
    va[1] = 32'd4; vb[1] = 32'd5; ve[1] = 1'b1;
    va[2] = 32'd6; vb[2] = 32'd5; ve[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a32 = va[i];
      b32 = vb[i];
      @(posedge clk); #1;
      checks++;
      if (z32 !== ve[i]) begin
        errors++;
        $display("FAIL ordering[%0d] a=%h b=%h: z=%b expected %b", i, va[i], vb[i], z32, ve[i]);
      end
    end
  endtask

  task automatic test_sign_boundary();
    logic [31:0] va [2];
    logic [31:0] vb [2];
    logic        ve [2];
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001;
    va[1] = 32'h8000_0000; vb[1] = 32'h7FFF_FFFF;
`ifdef LT_SIGNED_EN
    ve[0] = 1'b1; ve[1] = 1'b1;
`else
    ve[0] = 1'b0; ve[1] = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      a32 = va[i];
      b32 = vb[i];
      @(posedge clk); #1;
      checks++;
      if (z32 !== ve[i]) begin
        errors++;
        $display("FAIL sign_boundary[%0d] a=%h b=%h: z=%b expected %b", i, va[i], vb[i], z32, ve[i]);
      end
    end
    // Reversed operands: expected value is the complement in both modes.
    for (int i = 0; i < 2; i++) begin
      a32 = vb[i];
      b32 = va[i];
      @(posedge clk); #1;
      checks++;
      if (z32 !== ~ve[i]) begin
        errors++;
        $display("FAIL sign_boundary_rev[%0d] a=%h b=%h: z=%b expected %b", i, vb[i], va[i], z32, ~ve[i]);
      end
    end
  endtask

  task automatic test_slice_boundary();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        ve [4];
    va[0] = 32'h0100_FFFF; vb[0] = 32'h0101_0000; ve[0] = 1'b1;
    va[1] = 32'h1234_5678; vb[1] = 32'h1234_5677; ve[1] = 1'b0;
    va[2] = 32'h1234_5677; vb[2] = 32'h1234_5678; ve[2] = 1'b1;
    va[3] = 32'h12FF_FFFF; vb[3] = 32'h1300_0000; ve[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a32 = va[i];
      b32 = vb[i];
      @(posedge clk); #1;
      checks++;
      if (z32 !== ve[i]) begin
        errors++;
        $display("FAIL slice_boundary[%0d] a=%h b=%h: z=%b expected %b", i, va[i], vb[i], z32, ve[i]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic exp32;
    for (int i = 0; i < 20; i++) begin
      a32 = $urandom();
      b32 = $urandom();
      rst_n = (i == 10) ? 1'b0 : 1'b1;
      exp32 = (i == 10) ? 1'b0 : ref32(a32, b32);
      @(posedge clk); #1;
      checks++;
      if (z32 !== exp32) begin
        errors++;
        $display("FAIL midstream_reset[%0d] a=%h b=%h rst_n=%b: z=%b expected %b",
                 i, a32, b32, rst_n, z32, exp32);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random_sweep();
    logic exp32;
    logic exp12;
    int   bad32;
    int   bad12;
    bad32 = 0;
    bad12 = 0;
    for (int i = 0; i < 5000; i++) begin
      a32 = $urandom();
      b32 = $urandom();
      if ($urandom_range(9) == 0) b32 = a32;
      a12 = 12'($urandom());
      b12 = 12'($urandom());
      if ($urandom_range(9) == 0) b12 = a12;
      exp32 = ref32(a32, b32);
      exp12 = ref12(a12, b12);
      @(posedge clk); #1;
      checks++;
      if (z32 !== exp32) begin
        errors++;
        bad32++;
        if (bad32 <= 10)
          $display("FAIL random32[%0d] a=%h b=%h: z=%b expected %b", i, a32, b32, z32, exp32);
      end
      checks++;
      if (z12 !== exp12) begin
        errors++;
        bad12++;
        if (bad12 <= 10)
          $display("FAIL random12[%0d] a=%h b=%h: z=%b expected %b", i, a12, b12, z12, exp12);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a32 = '0;
    b32 = '0;
    a12 = '0;
    b12 = '0;
    test_reset();
    test_ordering();
    test_sign_boundary();
    test_slice_boundary();
    test_midstream_reset();
    test_random_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
